ppu_mode_scheduler: RTL

Dot-accurate PPU line/frame scheduler. Owns the dot counter and LY, sequences the mode-2 OAM search engine and the mode-3 pixel-transfer engine through start/done handshakes, and derives the STAT mode, LYC compare, CPU bus locks and the VBlank/STAT interrupt pulses. Sits between the LCDC/STAT register file and the PPU mode engines. Its lock outputs feed the OAM/VRAM bus arbiters.

---
 rtl/ppu_mode_scheduler.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ppu_mode_scheduler.sv
// PPU line/frame scheduler: dot/LY counters, mode 2/3 engine sequencing,
// STAT mode, LYC compare, CPU bus locks and interrupt pulses.
module ppu_mode_scheduler #(
  parameter int DOTS_PER_LINE = 456,
  parameter int VISIBLE_LINES = 144,
  parameter int TOTAL_LINES   = 154,
  parameter int OAM_DOTS      = 80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_lcd_en,
  input  logic [7:0] i_lyc,
  input  logic [3:0] i_stat_sel,
  output logic       o_mode2_start,
  input  logic       i_mode2_done,
  output logic       o_mode3_start,
  input  logic       i_mode3_done,
  output logic       o_mode3_abort,
  output logic [8:0] o_dot,
  output logic [7:0] o_ly,
  output logic [1:0] o_mode,
  output logic       o_lyc_eq,
  output logic       o_oam_cpu_lock,
  output logic       o_vram_cpu_lock,
  output logic       o_vblank_irq,
  output logic       o_stat_irq,
  output logic       o_overrun,
  input  logic       i_overrun_clr
);

  localparam logic [8:0] DOT_LAST = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] DOT_OAM  = 9'(OAM_DOTS - 1);
  localparam logic [7:0] LY_VIS   = 8'(VISIBLE_LINES);
  localparam logic [7:0] LY_LAST  = 8'(TOTAL_LINES - 1);

  typedef enum logic [2:0] {
    S_OFF,
    S_OAM,
    S_WAIT,
    S_XFER,
    S_HBL,
    S_VBL
  } state_t;

  state_t     r_state;
  state_t     w_state;
  state_t     w_nxt;
  logic [8:0] r_dot;
  logic [7:0] r_ly;
  logic [7:0] w_ly_nx;
  logic       r_m2_seen;
  logic       r_m3_start;
  logic       r_overrun;
  logic       r_line_q;
  logic       w_eol;
  logic       w_abort;
  logic       w_line;
  logic       w_lyc_eq;
  logic [1:0] w_mode;

  // Enabling from OFF shows line 0 / dot 0 in OAM within the same cycle.
  always_comb begin
    w_state = r_state;
    if (r_state == S_OFF && i_lcd_en && !rst)
      w_state = S_OAM;
  end

  assign w_eol    = (r_dot == DOT_LAST);
  assign w_ly_nx  = (r_ly == LY_LAST) ? 8'd0 : r_ly + 8'd1;
  assign w_lyc_eq = (r_ly == i_lyc);
  assign w_abort  = !rst && w_eol &&
                    (w_state == S_XFER || w_state == S_WAIT);

  always_comb begin
    w_nxt = w_state;
    case (w_state)
      S_OAM:
        if (r_dot == DOT_OAM)
          w_nxt = (r_m2_seen || i_mode2_done) ? S_XFER : S_WAIT;
      S_WAIT:
        if (i_mode2_done) w_nxt = S_XFER;
      S_XFER:
        if (i_mode3_done) w_nxt = S_HBL;
      default: ;
    endcase
    if (w_eol)
      w_nxt = (w_ly_nx < LY_VIS) ? S_OAM : S_VBL;
  end

  always_comb begin
    w_mode = 2'd0;
    unique case (1'b1)
      (w_state == S_OAM),
      (w_state == S_WAIT): w_mode = 2'd2;
      (w_state == S_XFER): w_mode = 2'd3;
      (w_state == S_VBL):  w_mode = 2'd1;
      default:             w_mode = 2'd0;
    endcase
  end

  assign w_line = i_lcd_en && (w_state != S_OFF) &&
                  ((i_stat_sel[3] && w_lyc_eq) ||
                   (i_stat_sel[2] && w_mode == 2'd2) ||
                   (i_stat_sel[1] && w_mode == 2'd1) ||
                   (i_stat_sel[0] && w_mode == 2'd0));

  always_ff @(posedge clk) begin
    if (rst || !i_lcd_en) begin
      r_state    <= S_OFF;
      r_dot      <= 9'd0;
      r_ly       <= 8'd0;
      r_m2_seen  <= 1'b0;
      r_m3_start <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_dot      <= w_eol ? 9'd0 : r_dot + 9'd1;
      r_ly       <= w_eol ? w_ly_nx : r_ly;
      r_m2_seen  <= w_eol ? 1'b0 :
                    (r_m2_seen || (w_state == S_OAM && i_mode2_done));
      r_m3_start <= (w_nxt == S_XFER) && (w_state != S_XFER);
    end
  end

  // Overrun survives LCD off; a coincident set beats the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun <= 1'b0;
      r_line_q  <= 1'b0;
    end else begin
      r_line_q <= w_line;
      if (w_abort)
        r_overrun <= 1'b1;
      else if (i_overrun_clr)
        r_overrun <= 1'b0;
    end
  end

  assign o_dot           = r_dot;
  assign o_ly            = r_ly;
  assign o_mode          = w_mode;
  assign o_lyc_eq        = w_lyc_eq;
  assign o_oam_cpu_lock  = w_mode[1];
  assign o_vram_cpu_lock = (w_mode == 2'd3);
  assign o_mode2_start   = (w_state == S_OAM) && (r_dot == 9'd0);
  assign o_mode3_start   = r_m3_start;
  assign o_mode3_abort   = w_abort;
  assign o_vblank_irq    = (w_state == S_VBL) && (r_dot == 9'd0) &&
                           (r_ly == LY_VIS);
  assign o_stat_irq      = w_line && !r_line_q;
  assign o_overrun       = r_overrun;

endmodule
